// File: rtl/sram_port_arb_if.sv
// Handshake and SRAM-pin bundle for sram_port_arb.
//   req0_*/req1_* : two requesters (valid/ready, we, addr, wdata, wmsk; wmsk bit 1 = keep old bit)
//   rsp0_*/rsp1_* : read responses (one-cycle valid pulse, data holds between pulses)
//   clr_*         : zero-fill request, busy flag and last-write pulse
//   sram_*        : single-port SRAM pins (active-low cen/wen, rdata valid the cycle after access)
// slave = arbiter side, master = requester/SRAM side.
interface sram_port_arb_if #(
  parameter int AW = 10,
  parameter int DW = 18
);
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_wmsk;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_wmsk;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          clr_start, clr_busy, clr_done;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_wmsk, sram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wmsk,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wmsk,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  clr_start,
    output clr_busy, clr_done,
    output sram_cen, sram_wen, sram_addr, sram_wdata, sram_wmsk,
    input  sram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_wmsk,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_wmsk,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output clr_start,
    input  clr_busy, clr_done,
    input  sram_cen, sram_wen, sram_addr, sram_wdata, sram_wmsk,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arb.sv
// Two-requester round-robin arbiter in front of a single-port SRAM, with a
// zero-fill clear engine that owns the port for DEPTH cycles.
//   clk   : rising-edge clock shared with the SRAM
//   rst_n : asynchronous active-low reset
//   bus   : sram_port_arb_if slave modport (requests, responses, clear, SRAM pins)
// Reads return on rspN two cycles after acceptance: the SRAM produces data one
// cycle after the access, and it is registered once more here.
module sram_port_arb #(
  parameter int AW    = 10,
  parameter int DW    = 18,
  parameter int DEPTH = 1024
) (
  input logic           clk,
  input logic           rst_n,
  sram_port_arb_if.slave bus
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;       // 1 = req1 granted most recently
  logic [1:0]         rd_s1_q, rd_s1_d;     // read issued last cycle, one bit per requester
  logic [1:0]         rsp_vld_q, rsp_vld_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic          gnt0, gnt1, clr_last, issue, iss_we;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata, iss_wmsk;

  always_comb begin
    // Grants are gated by rst_n so ready stays low while reset is held.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end

    clr_last = (state_q == CLEAR) && (cnt_q == CW'(DEPTH - 1));

    issue     = 1'b0;
    iss_we    = 1'b0;
    iss_addr  = '0;
    iss_wdata = '0;
    iss_wmsk  = '0;
    if (state_q == CLEAR) begin
      issue    = 1'b1;
      iss_we   = 1'b1;
      iss_addr = AW'(cnt_q);
    end else if (gnt0) begin
      issue     = 1'b1;
      iss_we    = bus.req0_we;
      iss_addr  = bus.req0_addr;
      iss_wdata = bus.req0_wdata;
      iss_wmsk  = bus.req0_wmsk;
    end else if (gnt1) begin
      issue     = 1'b1;
      iss_we    = bus.req1_we;
      iss_addr  = bus.req1_addr;
      iss_wdata = bus.req1_wdata;
      iss_wmsk  = bus.req1_wmsk;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (bus.clr_start) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    end else if (clr_last) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;

    rd_s1_d   = {gnt1 & ~bus.req1_we, gnt0 & ~bus.req0_we};
    rsp_vld_d = rd_s1_q;
    rdata_d   = rdata_q;
    for (int n = 0; n < 2; n++)
      if (rd_s1_q[n]) rdata_d[n] = bus.sram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rd_s1_q   <= '0;
      rsp_vld_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_s1_q   <= rd_s1_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_rdata = rdata_q[0];
  assign bus.rsp1_rdata = rdata_q[1];
  assign bus.clr_busy   = (state_q == CLEAR);
  assign bus.clr_done   = clr_last;
  assign bus.sram_cen   = ~issue;
  assign bus.sram_wen   = ~(issue & iss_we);
  assign bus.sram_addr  = iss_addr;
  assign bus.sram_wdata = iss_wdata;
  assign bus.sram_wmsk  = iss_wmsk;
endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: behavioural SRAM, a transaction-level reference
// model (round-robin winner, word memory, response timeline), and scenario tasks.
module tb_sram_port_arb;
  localparam int AW = 10, DW = 18, DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arb_if #(.AW(AW), .DW(DW)) bus();
  sram_port_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // SRAM: masked write, read data registered at the access edge
  bit [DW-1:0] sram_mem [DEPTH];
  bit [DW-1:0] sram_q;
  always @(posedge clk)
    if (!bus.sram_cen) begin
      if (!bus.sram_wen)
        sram_mem[bus.sram_addr] <= (sram_mem[bus.sram_addr] & bus.sram_wmsk) | (bus.sram_wdata & ~bus.sram_wmsk);
      else
        sram_q <= sram_mem[bus.sram_addr];
    end
  assign bus.sram_rdata = sram_q;

  int n_chk = 0, n_fail = 0;

  // reference model state
  bit [DW-1:0] ref_mem [DEPTH];
  int m_last, m_cnt, s1_req;
  bit m_busy, s1_v;
  bit [DW-1:0] s1_d;
  bit m_rv [2];
  bit [DW-1:0] m_rd [2];
  // expectations for the current cycle
  int e_win;
  bit e_rdy [2];
  bit e_cen, e_wen, e_busy, e_done;
  bit [AW-1:0] e_addr;
  bit [DW-1:0] e_wdata, e_wmsk;
  bit e_rv [2];
  bit [DW-1:0] e_rd [2];

  task automatic model_reset();
    m_last = 1; m_busy = 0; m_cnt = 0; s1_v = 0;
    for (int i = 0; i < 2; i++) begin m_rv[i] = 0; m_rd[i] = '0; end
  endtask

  task automatic drv(input int n, input bit v, input bit we, input int addr, input int d, input int m);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = AW'(addr);
      bus.req0_wdata = DW'(d); bus.req0_wmsk = DW'(m);
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = AW'(addr);
      bus.req1_wdata = DW'(d); bus.req1_wmsk = DW'(m);
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    bus.clr_start = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Wait to mid-cycle, compute this cycle's expectations, then advance the model.
  task automatic sample();
    bit v [2]; bit we [2]; bit [AW-1:0] a [2]; bit [DW-1:0] wd [2], wm [2];
    @(negedge clk);
    v[0] = bus.req0_valid; we[0] = bus.req0_we; a[0] = bus.req0_addr; wd[0] = bus.req0_wdata; wm[0] = bus.req0_wmsk;
    v[1] = bus.req1_valid; we[1] = bus.req1_we; a[1] = bus.req1_addr; wd[1] = bus.req1_wdata; wm[1] = bus.req1_wmsk;
    e_win = -1;
    if (!m_busy) begin
      if (v[0] && v[1]) e_win = 1 - m_last;
      else if (v[0])    e_win = 0;
      else if (v[1])    e_win = 1;
    end
    e_rdy[0] = (e_win == 0);
    e_rdy[1] = (e_win == 1);
    e_cen = 1; e_wen = 1; e_addr = '0; e_wdata = '0; e_wmsk = '0;
    if (m_busy) begin
      e_cen = 0; e_wen = 0; e_addr = AW'(m_cnt);
    end else if (e_win >= 0) begin
      e_cen = 0; e_wen = !we[e_win]; e_addr = a[e_win]; e_wdata = wd[e_win]; e_wmsk = wm[e_win];
    end
    e_busy = m_busy;
    e_done = m_busy && (m_cnt == DEPTH - 1);
    for (int i = 0; i < 2; i++) begin e_rv[i] = m_rv[i]; e_rd[i] = m_rd[i]; end
    // advance to next cycle
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = s1_v && (s1_req == i);
      if (m_rv[i]) m_rd[i] = s1_d;
    end
    s1_v = 0;
    if (e_win >= 0) begin
      if (we[e_win]) ref_mem[a[e_win]] = (ref_mem[a[e_win]] & wm[e_win]) | (wd[e_win] & ~wm[e_win]);
      else begin s1_v = 1; s1_req = e_win; s1_d = ref_mem[a[e_win]]; end
      m_last = e_win;
    end
    if (m_busy) begin
      ref_mem[m_cnt] = '0;
      if (m_cnt == DEPTH - 1) m_busy = 0; else m_cnt++;
    end else if (bus.clr_start) begin
      m_busy = 1; m_cnt = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(0, 1, 0, 7, 0, 0); drv(1, 1, 0, 8, 0, 0); bus.clr_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready, bus.sram_cen, bus.sram_wen, bus.rsp0_valid, bus.rsp1_valid,
         bus.clr_busy, bus.clr_done} !== 8'b0011_0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00110000", {bus.req0_ready, bus.req1_ready, bus.sram_cen,
               bus.sram_wen, bus.rsp0_valid, bus.rsp1_valid, bus.clr_busy, bus.clr_done});
    end
    n_chk++;
    if ({bus.rsp0_rdata, bus.rsp1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.rsp0_rdata, bus.rsp1_rdata);
    end
    // release: grant possible in the very first cycle, req0 wins the first tie
    next();
    rst_n = 1'b1; bus.clr_start = 1'b0;
    model_reset();
    sample();
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready});
    end
    // reset with a read in flight drops its response
    next();
    rst_n = 1'b0; idle(); model_reset();
    #1;
    n_chk++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.sram_cen} !== 3'b001) begin
      n_fail++; $display("FAIL reset_inflight got=%b exp=001", {bus.rsp0_valid, bus.rsp1_valid, bus.sram_cen});
    end
    next();
    rst_n = 1'b1;
    repeat (3) begin
      sample();
      n_chk++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
        n_fail++; $display("FAIL dropped_rsp got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid});
      end
      next();
    end
  endtask

  task automatic test_raw();
    idle(); drv(0, 1, 1, 5, 'h2AAAA, 0);
    sample();
    n_chk++;
    if ({bus.req0_ready, bus.sram_cen, bus.sram_wen, bus.sram_addr} !== {1'b1, 1'b0, 1'b0, AW'(5)}) begin
      n_fail++; $display("FAIL raw_write_issue rdy=%b cen=%b wen=%b addr=%0d", bus.req0_ready, bus.sram_cen, bus.sram_wen, bus.sram_addr);
    end
    next();
    idle(); drv(1, 1, 0, 5, 0, 0);
    sample();
    n_chk++;
    if ({bus.req1_ready, bus.sram_wen} !== 2'b11) begin
      n_fail++; $display("FAIL raw_read_issue got=%b exp=11", {bus.req1_ready, bus.sram_wen});
    end
    next();
    idle();
    sample();
    n_chk++;
    if (bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL raw_early_rsp got=%b exp=0", bus.rsp1_valid); end
    next();
    sample();
    n_chk++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_rdata} !== {2'b01, 18'h2AAAA} || bus.rsp1_rdata !== e_rd[1]) begin
      n_fail++; $display("FAIL raw_rsp v=%b%b data=%h exp=01 2aaaa", bus.rsp0_valid, bus.rsp1_valid, bus.rsp1_rdata);
    end
    next();
  endtask

  task automatic test_alternate();
    idle();
    rst_n = 1'b0; model_reset();
    next();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drv(0, 1, 0, i, 0, 0); drv(1, 1, 0, i + 16, 0, 0);
      sample();
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alternate[%0d] got=%b exp=%b", i, {bus.req0_ready, bus.req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      next();
    end
    idle();
    repeat (3) begin
      sample();
      n_chk++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata} !== {e_rv[0], e_rv[1], e_rd[0], e_rd[1]}) begin
        n_fail++; $display("FAIL alternate_rsp got=%b%b %h %h exp=%b%b %h %h", bus.rsp0_valid, bus.rsp1_valid,
                           bus.rsp0_rdata, bus.rsp1_rdata, e_rv[0], e_rv[1], e_rd[0], e_rd[1]);
      end
      next();
    end
  endtask

  task automatic test_mask();
    idle(); drv(1, 1, 1, 9, 'h3FFFF, 0);     sample(); next();
    idle(); drv(0, 1, 1, 9, 'h0, 'h3FF00);   sample(); next();
    idle(); drv(0, 1, 0, 9, 0, 0);           sample(); next();
    idle();                                  sample(); next();
    sample();
    n_chk++;
    if ({bus.rsp0_valid, bus.rsp0_rdata} !== {1'b1, 18'h3FF00}) begin
      n_fail++; $display("FAIL mask_rsp got=%b %h exp=1 3ff00", bus.rsp0_valid, bus.rsp0_rdata);
    end
    next();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      idle(); drv(i % 2, 1, 1, i, 'h100 + i, 0); sample(); next();
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) drv(0, 1, 0, i, 0, 0);
      sample();
      if (i >= 2) begin
        n_chk++;
        if ({bus.rsp0_valid, bus.rsp0_rdata} !== {1'b1, DW'('h100 + i - 2)}) begin
          n_fail++; $display("FAIL b2b[%0d] got=%b %h exp=1 %h", i - 2, bus.rsp0_valid, bus.rsp0_rdata, DW'('h100 + i - 2));
        end
      end
      next();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++)
        drv(n, ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom & 'h3FFFF & (($urandom_range(0, 1) != 0) ? 'h3FFFF : 0));
      bus.clr_start = 1'b0;
      sample();
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== {e_rdy[0], e_rdy[1]}) begin
        n_fail++; $display("FAIL rnd_ready[%0d] got=%b%b exp=%b%b", c, bus.req0_ready, bus.req1_ready, e_rdy[0], e_rdy[1]);
      end
      n_chk++;
      if ({bus.sram_cen, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.sram_wmsk} !== {e_cen, e_wen, e_addr, e_wdata, e_wmsk}) begin
        n_fail++; $display("FAIL rnd_pins[%0d] got=%b%b %h %h %h exp=%b%b %h %h %h", c, bus.sram_cen, bus.sram_wen, bus.sram_addr,
                           bus.sram_wdata, bus.sram_wmsk, e_cen, e_wen, e_addr, e_wdata, e_wmsk);
      end
      n_chk++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata} !== {e_rv[0], e_rv[1], e_rd[0], e_rd[1]}) begin
        n_fail++; $display("FAIL rnd_rsp[%0d] got=%b%b %h %h exp=%b%b %h %h", c, bus.rsp0_valid, bus.rsp1_valid,
                           bus.rsp0_rdata, bus.rsp1_rdata, e_rv[0], e_rv[1], e_rd[0], e_rd[1]);
      end
      next();
    end
    idle();
    repeat (2) begin sample(); next(); end
  endtask

  task automatic test_clear();
    int busy_cyc = 0, done_cnt = 0, rdy_viol = 0;
    idle(); drv(1, 1, 1, 1023, 'h1234, 0); sample(); next();
    idle(); drv(1, 1, 1, 1, 'h55, 0);      sample(); next();
    // clr_start together with a read: the read is granted this cycle
    idle(); drv(0, 1, 0, 1023, 0, 0); bus.clr_start = 1'b1;
    sample();
    n_chk++;
    if ({bus.req0_ready, bus.clr_busy} !== 2'b10) begin
      n_fail++; $display("FAIL clr_same_cycle_grant got=%b exp=10", {bus.req0_ready, bus.clr_busy});
    end
    next();
    for (int i = 0; i < DEPTH + 6; i++) begin
      bus.clr_start = (i == 500);
      sample();
      busy_cyc += bus.clr_busy;
      done_cnt += bus.clr_done;
      if (bus.clr_busy && bus.req0_ready) rdy_viol++;
      if (bus.clr_done) begin
        n_chk++;
        if ({bus.sram_cen, bus.sram_wen, bus.sram_addr, bus.sram_wdata, bus.sram_wmsk} !== {2'b00, AW'(DEPTH - 1), {2*DW{1'b0}}}) begin
          n_fail++; $display("FAIL clr_done_addr got=%b%b %h %h %h exp=00 %h 0 0", bus.sram_cen, bus.sram_wen,
                             bus.sram_addr, bus.sram_wdata, bus.sram_wmsk, AW'(DEPTH - 1));
        end
      end
      if (i == 1) begin
        n_chk++;
        if ({bus.rsp0_valid, bus.clr_busy, bus.rsp0_rdata} !== {2'b11, 18'h01234}) begin
          n_fail++; $display("FAIL clr_preread got=%b%b %h exp=11 01234", bus.rsp0_valid, bus.clr_busy, bus.rsp0_rdata);
        end
      end
      if (i >= DEPTH + 2) begin
        n_chk++;
        if ({bus.rsp0_valid, bus.rsp0_rdata} !== {1'b1, {DW{1'b0}}} || bus.rsp0_rdata !== e_rd[0]) begin
          n_fail++; $display("FAIL clr_postread got=%b %h exp=1 0", bus.rsp0_valid, bus.rsp0_rdata);
        end
      end
      next();
    end
    n_chk++;
    if (busy_cyc != DEPTH) begin n_fail++; $display("FAIL clr_busy_cycles got=%0d exp=%0d", busy_cyc, DEPTH); end
    n_chk++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL clr_done_count got=%0d exp=1", done_cnt); end
    n_chk++;
    if (rdy_viol != 0) begin n_fail++; $display("FAIL clr_ready_during_busy got=%0d exp=0", rdy_viol); end
    idle(); drv(1, 1, 0, 1, 0, 0); sample(); next();
    idle(); sample(); next();
    sample();
    n_chk++;
    if ({bus.rsp1_valid, bus.rsp1_rdata} !== {1'b1, {DW{1'b0}}}) begin
      n_fail++; $display("FAIL clr_addr1 got=%b %h exp=1 0", bus.rsp1_valid, bus.rsp1_rdata);
    end
    next();
  endtask

  task automatic test_clear_abort();
    int guard = 0;
    idle(); bus.clr_start = 1'b1; sample(); next();
    idle();
    while (m_cnt != 300 && guard < DEPTH) begin sample(); next(); guard++; end
    @(negedge clk);
    n_chk++;
    if ({bus.clr_busy, bus.sram_cen, bus.sram_addr} !== {2'b10, AW'(300)}) begin
      n_fail++; $display("FAIL abort_reach got=%b%b %0d exp=10 300", bus.clr_busy, bus.sram_cen, bus.sram_addr);
    end
    rst_n = 1'b0; model_reset();
    #1;
    n_chk++;
    if ({bus.clr_busy, bus.clr_done, bus.sram_cen, bus.sram_wen} !== 4'b0011) begin
      n_fail++; $display("FAIL abort_now got=%b exp=0011", {bus.clr_busy, bus.clr_done, bus.sram_cen, bus.sram_wen});
    end
    next();
    rst_n = 1'b1;
    repeat (4) begin
      sample();
      n_chk++;
      if ({bus.clr_busy, bus.clr_done, bus.sram_cen} !== 3'b001) begin
        n_fail++; $display("FAIL abort_after got=%b exp=001", {bus.clr_busy, bus.clr_done, bus.sram_cen});
      end
      next();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    test_reset();
    test_raw();
    test_alternate();
    test_mask();
    test_back_to_back();
    test_random();
    test_clear();
    test_clear_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning SRAM word-address width.
REQ-002 The block SHALL have parameter DW, default 18, meaning SRAM data and mask width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of words swept by clear.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, width 1: rising-edge clock shared with the SRAM port it drives.
REQ-006 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have ports reqN_valid, input, width 1, for N=0,1: request present.
REQ-008 The block SHALL have ports reqN_ready, output, width 1: request accepted this cycle.
REQ-009 The block SHALL have ports reqN_we, input, width 1: 1 = write, 0 = read.
REQ-010 The block SHALL have ports reqN_addr, input, width AW: word address.
REQ-011 The block SHALL have ports reqN_wdata, input, width DW: write data.
REQ-012 The block SHALL have ports reqN_wmsk, input, width DW: per-bit write mask, 1 = bit keeps its old value.
REQ-013 The block SHALL have ports rspN_valid, output, width 1: read data valid, one-cycle pulse.
REQ-014 The block SHALL have ports rspN_rdata, output, width DW: read data.
REQ-015 The block SHALL have port clr_start, input, width 1: pulse requesting a zero-fill of the whole SRAM.
REQ-016 The block SHALL have port clr_busy, output, width 1: clear sequence in progress.
REQ-017 The block SHALL have port clr_done, output, width 1: one-cycle pulse when the last clear write issues.
REQ-018 The block SHALL have port sram_cen, output, width 1: SRAM chip enable, active low.
REQ-019 The block SHALL have port sram_wen, output, width 1: SRAM write enable, active low.
REQ-020 The block SHALL have ports sram_addr (width AW), sram_wdata (width DW) and sram_wmsk (width DW), all outputs, driving the corresponding SRAM pins.
REQ-021 The block SHALL have port sram_rdata, input, width DW: SRAM read data, valid in the cycle after the access cycle.

Function
REQ-022 Each cycle, at most one access SHALL be issued: either the clear engine or one granted requester.
REQ-023 sram_cen, sram_wen, sram_addr, sram_wdata and sram_wmsk SHALL be combinational from the current grant, with sram_cen=0 only in an issue cycle.
REQ-024 sram_wen SHALL equal ~we of the issued access, and sram_wmsk/sram_wdata SHALL pass through unmodified.
REQ-025 In idle cycles (no issue), sram_cen=1, sram_wen=1, and sram_addr/sram_wdata/sram_wmsk SHALL be 0.
REQ-026 reqN_ready SHALL be 1 only when requester N is granted; an access transfers when valid & ready, and ready SHALL never be asserted without valid.
REQ-027 Arbitration SHALL be round-robin:
- When only one requester is valid, it wins.
- When both are valid, the requester not granted most recently wins.
- A 1-bit last-grant register holds the most recent grant and resets to 1, so req0 wins the first tie.
REQ-028 A read accepted in cycle T SHALL produce rspN_valid=1 in cycle T+2, for the accepting requester only, with rspN_rdata equal to sram_rdata registered at the end of cycle T+1.
REQ-029 Writes SHALL produce no response.
REQ-030 Back-to-back reads SHALL sustain one response per cycle, and responses SHALL be returned in acceptance order with no backpressure.
REQ-031 rspN_rdata SHALL hold its last value when rspN_valid=0.
REQ-032 Clear state machine SHALL have states IDLE and CLEAR, with the following transitions:
- IDLE to CLEAR on clr_start=1 at a clock edge; clr_busy=1 from the next cycle.
- In CLEAR, issue a write each cycle with wdata=0, wmsk=0, and the address counter going 0,1,...,DEPTH-1.
- After address DEPTH-1 issues: pulse clr_done in that same cycle, then return to IDLE (clr_busy=0 the next cycle).
REQ-033 During CLEAR, both reqN_ready SHALL be 0, and clr_start SHALL be ignored.
REQ-034 A clr_start in the same cycle as requests SHALL let that cycle's request grant proceed, with the clear starting the next cycle.
REQ-035 Reads accepted before CLEAR SHALL still complete at T+2 during CLEAR.
REQ-036 The clear address counter SHALL be log2(DEPTH) bits wide and reset to 0 on entering CLEAR.
REQ-037 Read-after-write to the same address by any requesters in consecutive cycles SHALL be issued in order without stall, so the read returns the written data.

Reset
REQ-038 While rst_n=0, asynchronously:
- State SHALL be IDLE and the clear counter 0.
- last-grant SHALL be 1.
- Response pipeline valids SHALL be cleared.
- rspN_valid=0, rspN_rdata=0, clr_busy=0, clr_done=0 and reqN_ready=0.
- sram_cen=1 and sram_wen=1.
REQ-039 Reset asserted mid-clear SHALL abort the sweep without a clr_done pulse, and reset asserted with reads in flight SHALL drop their responses.
REQ-040 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-041 Write req0 addr 5 data 0x2AAAA wmsk 0, then read req1 addr 5 -> rsp1_valid two cycles after the read accept, rsp1_rdata=0x2AAAA, rsp0_valid stays 0.
REQ-042 Both requesters continuously valid for 6 cycles after reset -> grants alternate 0,1,0,1,0,1.
REQ-043 Write 0x3FFFF to addr 9, then write 0x00000 with wmsk 0x3FF00, then read addr 9 -> rdata=0x3FF00.
REQ-044 Pulse clr_start, then hold req0_valid -> clr_busy high for exactly DEPTH cycles, req0_ready=0 throughout, clr_done pulses once, and a subsequent read of addr 1023 returns 0.
REQ-045 Assert rst_n=0 at clear address 300 -> clr_busy drops immediately, no clr_done, and sram_cen=1.
REQ-046 Issue 4 back-to-back reads req0 addrs 0-3 -> 4 consecutive rsp0_valid cycles with data in address order.
